// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared types and helpers for the AES ShiftRows/MixColumns round stage.
//   aes_byte_t / aes_col_t / aes_state_t : byte, 32-bit column, 128-bit state
//   shift_mix_state_t                    : control FSM states of shift_mix_stage
//   xtime()                              : GF(2^8) multiply by 2
//   shift_rows()                         : AES ShiftRows on a column-major state
//   get_col()                            : extract column c (0..3) of a state
// State layout is column-major: byte s[r][c] = data[127-8*(4c+r) -: 8].
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } shift_mix_state_t;

    function automatic aes_byte_t xtime(input aes_byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Row r is rotated left by r byte positions: s'[r][c] = s[r][(c+r) mod 4].
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic aes_col_t get_col(input aes_state_t s, input logic [1:0] c);
        return s[127 - 32*int'(c) -: 32];
    endfunction

endpackage

// File: rtl/mix_column.sv
// ----------------------------------------------------------------------------
// mix_column
// Combinational AES MixColumns on one 32-bit column.
// Ports:
//   col_i  in  32  column {s0,s1,s2,s3}, s0 (row 0) in bits [31:24]
//   col_o  out 32  mixed column, same byte order
// Matrix rows: {02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02}.
// ----------------------------------------------------------------------------
module mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    aes_byte_t a0, a1, a2, a3;
    aes_byte_t x0, x1, x2, x3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // Multiply by 3 is expressed as xtime(a) ^ a.
    assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/shift_mix_stage.sv
// ----------------------------------------------------------------------------
// shift_mix_stage
// AES-128 round stage following SubBytes: ShiftRows, then an iterative
// MixColumns processing COLS_PER_CYCLE columns per clock. The final round
// (last_round=1) bypasses MixColumns. Valid/ready handshake on both sides;
// one block in flight at a time.
// Parameters:
//   COLS_PER_CYCLE  columns mixed per clock (1, 2 or 4)
// Ports:
//   clk         in   1    clock, rising edge
//   rst         in   1    synchronous active-high reset
//   in_valid    in   1    in_data/last_round valid
//   in_ready    out  1    high only while IDLE
//   in_data     in   128  SubBytes output state
//   last_round  in   1    1 = skip MixColumns
//   out_valid   out  1    high while DONE
//   out_ready   in   1    downstream accepts out_data
//   out_data    out  128  ShiftRows(+MixColumns) result, zero when not DONE
// ----------------------------------------------------------------------------
module shift_mix_stage
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("shift_mix_stage: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // col_cnt is 2 bits; a step of 4 truncates to 0, which is exactly the wrap.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_OFS = 2'(COLS_PER_CYCLE - 1);

    shift_mix_state_t state_q, state_d;
    logic [1:0]       col_cnt_q, col_cnt_d;
    logic             last_q, last_d;
    aes_state_t       work_q, work_d;

    logic [1:0]       col_idx [COLS_PER_CYCLE];
    aes_col_t         mix_in  [COLS_PER_CYCLE];
    aes_col_t         mix_out [COLS_PER_CYCLE];
    logic [1:0]       top_col;

    // One mixer per column handled this cycle; mixer k works on col_cnt+k.
    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
            assign col_idx[k] = col_cnt_q + 2'(k);
            assign mix_in[k]  = get_col(work_q, col_idx[k]);

            mix_column u_mix_column (
                .col_i (mix_in[k]),
                .col_o (mix_out[k])
            );
        end
    endgenerate

    // Highest column index written this cycle; reaching 3 finishes the block.
    assign top_col = col_cnt_q + LAST_OFS;

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        last_d    = last_q;
        work_d    = work_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d    = shift_rows(in_data);
                    last_d    = last_round;
                    col_cnt_d = 2'd0;
                    state_d   = last_round ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!last_q) begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                        work_d[127 - 32*int'(col_idx[k]) -: 32] = mix_out[k];
                    end
                end
                col_cnt_d = col_cnt_q + COL_STEP;
                if (top_col == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            last_q    <= last_d;
        end
    end

    // The work register carries no reset: out_data is masked outside DONE,
    // so stale contents are never visible.
    always_ff @(posedge clk) begin
        work_q <= work_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? work_q : '0;

endmodule
